// File: rtl/camera_pkg.sv
// camera_pkg: shared types and constants for the camera control block.
//   state_t            - top-level FSM states
//   EXP_MIN / EXP_MAX  - exposure time limits in ms (EXP_MIN is also the reset value)
//   RD_LEN             - number of readout cycles
//   ADC1 / GAP1 / ADC2 - readout step indices for the row-1 ADC strobe,
//                        the inter-row gap and the row-2 ADC strobe
package camera_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXPOSE  = 2'd1,
    READOUT = 2'd2
  } state_t;

  localparam int EXP_MIN = 2;
  localparam int EXP_MAX = 30;
  localparam int RD_LEN  = 8;

  localparam logic [2:0] ADC1 = 3'd1;
  localparam logic [2:0] GAP1 = 3'd3;
  localparam logic [2:0] ADC2 = 3'd5;

endpackage

// File: rtl/edge_detect.sv
// edge_detect: rising-edge detector with a registered delayed copy.
//   Clk, Reset - clock, async active-high reset (delayed copy clears to 0)
//   d          - level input
//   rise       - high while d is high and was low at the previous edge
module edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/camera_ctrl.sv
// camera_ctrl: top-level camera control FSM.
//   Clk, Reset                 - 1 kHz clock, async active-high reset
//   Init                       - take-picture request (rising edge)
//   Exp_increase/Exp_decrease  - exposure adjust buttons (rising edge, idle only)
//   Ovf5                       - exposure timer elapsed
//   Start, Exp_Time            - exposure timer control
//   Erase, Expose, NRE_1, NRE_2, ADC - pixel array control lines
// All outputs are registered and decoded from the next state / next readout
// count, so they move on the same edge as the state.
module camera_ctrl #(
  parameter int EXP_MIN = camera_pkg::EXP_MIN,
  parameter int EXP_MAX = camera_pkg::EXP_MAX,
  parameter int RD_LEN  = camera_pkg::RD_LEN
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Init,
  input  logic       Exp_increase,
  input  logic       Exp_decrease,
  input  logic       Ovf5,
  output logic       Start,
  output logic [4:0] Exp_Time,
  output logic       Erase,
  output logic       Expose,
  output logic       NRE_1,
  output logic       NRE_2,
  output logic       ADC
);

  import camera_pkg::*;

  localparam logic [4:0] EXP_MIN_W = 5'(EXP_MIN);
  localparam logic [4:0] EXP_MAX_W = 5'(EXP_MAX);
  localparam logic [2:0] RD_LAST   = 3'(RD_LEN - 1);

  logic init_rise, inc_rise, dec_rise;

  edge_detect u_init (.Clk(Clk), .Reset(Reset), .d(Init),         .rise(init_rise));
  edge_detect u_inc  (.Clk(Clk), .Reset(Reset), .d(Exp_increase), .rise(inc_rise));
  edge_detect u_dec  (.Clk(Clk), .Reset(Reset), .d(Exp_decrease), .rise(dec_rise));

  state_t     state, state_nxt;
  logic [2:0] rd_cnt, rd_cnt_nxt;
  logic [4:0] exp_nxt;
  logic       start_nxt, erase_nxt, expose_nxt, nre1_nxt, nre2_nxt, adc_nxt;

  // State, counter, exposure and output registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      rd_cnt   <= 3'd0;
      Exp_Time <= EXP_MIN_W;
      Start    <= 1'b0;
      Erase    <= 1'b1;
      Expose   <= 1'b0;
      NRE_1    <= 1'b1;
      NRE_2    <= 1'b1;
      ADC      <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_cnt   <= rd_cnt_nxt;
      Exp_Time <= exp_nxt;
      Start    <= start_nxt;
      Erase    <= erase_nxt;
      Expose   <= expose_nxt;
      NRE_1    <= nre1_nxt;
      NRE_2    <= nre2_nxt;
      ADC      <= adc_nxt;
    end
  end

  // Next state, readout count and exposure time
  always_comb begin
    state_nxt  = state;
    rd_cnt_nxt = rd_cnt;
    exp_nxt    = Exp_Time;
    case (state)
      IDLE: begin
        // Simultaneous increase and decrease cancel out.
        if (inc_rise && !dec_rise && Exp_Time < EXP_MAX_W)
          exp_nxt = Exp_Time + 5'd1;
        else if (dec_rise && !inc_rise && Exp_Time > EXP_MIN_W)
          exp_nxt = Exp_Time - 5'd1;
        if (init_rise) begin
          state_nxt  = EXPOSE;
          rd_cnt_nxt = 3'd0;
        end
      end
      EXPOSE: begin
        if (Ovf5) begin
          state_nxt  = READOUT;
          rd_cnt_nxt = 3'd0;
        end
      end
      READOUT: begin
        if (rd_cnt == RD_LAST) begin
          state_nxt  = IDLE;
          rd_cnt_nxt = 3'd0;
        end else begin
          rd_cnt_nxt = rd_cnt + 3'd1;
        end
      end
      default: begin
        state_nxt  = IDLE;
        rd_cnt_nxt = 3'd0;
      end
    endcase
  end

  // Output decode from next state / next count
  always_comb begin
    start_nxt  = 1'b0;
    erase_nxt  = 1'b1;
    expose_nxt = 1'b0;
    nre1_nxt   = 1'b1;
    nre2_nxt   = 1'b1;
    adc_nxt    = 1'b0;
    case (state_nxt)
      EXPOSE: begin
        start_nxt  = 1'b1;
        erase_nxt  = 1'b0;
        expose_nxt = 1'b1;
      end
      READOUT: begin
        erase_nxt = 1'b0;
        // Row 1 before the gap, row 2 between the gap and the final step.
        nre1_nxt  = !(rd_cnt_nxt < GAP1);
        nre2_nxt  = !(rd_cnt_nxt > GAP1 && rd_cnt_nxt < RD_LAST);
        adc_nxt   = (rd_cnt_nxt == ADC1) || (rd_cnt_nxt == ADC2);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_camera_ctrl.sv
module tb_camera_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Init = 1'b0, Exp_increase = 1'b0, Exp_decrease = 1'b0, Ovf5 = 1'b0;
  logic       Start, Erase, Expose, NRE_1, NRE_2, ADC;
  logic [4:0] Exp_Time;

  camera_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Init(Init), .Exp_increase(Exp_increase),
    .Exp_decrease(Exp_decrease), .Ovf5(Ovf5), .Start(Start), .Exp_Time(Exp_Time),
    .Erase(Erase), .Expose(Expose), .NRE_1(NRE_1), .NRE_2(NRE_2), .ADC(ADC)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Reference model: picture-taking as "busy / exposing / cycles since Ovf5".
  int m_exp;
  bit m_busy, m_exposing;
  int m_since;
  bit p_init, p_inc, p_dec;

  function automatic logic [10:0] o(int e, bit st, bit er, bit ex, bit n1, bit n2, bit ad);
    return {5'(e), st, er, ex, n1, n2, ad};
  endfunction

  function automatic logic [10:0] model_out();
    if (!m_busy)   return o(m_exp, 0, 1, 0, 1, 1, 0);
    if (m_exposing) return o(m_exp, 1, 0, 1, 1, 1, 0);
    // readout: row 1 on steps 0-2, gap 3, row 2 on steps 4-6, gap 7
    return o(m_exp, 0, 0, 0, !(m_since <= 2), !(m_since >= 4 && m_since <= 6),
             m_since == 1 || m_since == 5);
  endfunction

  task automatic model_reset();
    m_exp = 2; m_busy = 0; m_exposing = 0; m_since = 0;
    p_init = 0; p_inc = 0; p_dec = 0;
  endtask

  task automatic model_step();
    bit ri, ru, rd;
    ri = Init && !p_init; ru = Exp_increase && !p_inc; rd = Exp_decrease && !p_dec;
    if (!m_busy) begin
      if (ru && !rd && m_exp < 30) m_exp++;
      if (rd && !ru && m_exp > 2)  m_exp--;
      if (ri) begin m_busy = 1; m_exposing = 1; end
    end else if (m_exposing) begin
      if (Ovf5) begin m_exposing = 0; m_since = 0; end
    end else begin
      m_since++;
      if (m_since == 8) m_busy = 0;
    end
    p_init = Init; p_inc = Exp_increase; p_dec = Exp_decrease;
  endtask

  function automatic logic [10:0] dut_out();
    return {Exp_Time, Start, Erase, Expose, NRE_1, NRE_2, ADC};
  endfunction

  task automatic check(string name, logic [10:0] act, logic [10:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (time %0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(string name, logic [4:0] act, logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    if (Reset) model_reset(); else model_step();
    #1;
    check("model", dut_out(), model_out());
  endtask

  task automatic press_inc();
    Exp_increase = 1; tick(); Exp_increase = 0; tick();
  endtask
  task automatic press_dec();
    Exp_decrease = 1; tick(); Exp_decrease = 0; tick();
  endtask

  typedef struct {
    bit inc, dec, init, ovf;
    logic [10:0] exp;
  } vec_t;
  vec_t tbl[24];

  function automatic vec_t v(bit inc, bit dec, bit init, bit ovf, logic [10:0] e);
    vec_t r;
    r.inc = inc; r.dec = dec; r.init = init; r.ovf = ovf; r.exp = e;
    return r;
  endfunction

  initial begin
    tbl[0]  = v(1, 0, 0, 0, o(3, 0, 1, 0, 1, 1, 0));
    tbl[1]  = v(0, 0, 0, 0, o(3, 0, 1, 0, 1, 1, 0));
    tbl[2]  = v(1, 1, 0, 0, o(3, 0, 1, 0, 1, 1, 0));
    tbl[3]  = v(0, 0, 0, 0, o(3, 0, 1, 0, 1, 1, 0));
    tbl[4]  = v(0, 1, 0, 0, o(2, 0, 1, 0, 1, 1, 0));
    tbl[5]  = v(0, 0, 0, 0, o(2, 0, 1, 0, 1, 1, 0));
    tbl[6]  = v(0, 1, 0, 0, o(2, 0, 1, 0, 1, 1, 0));
    tbl[7]  = v(0, 0, 0, 0, o(2, 0, 1, 0, 1, 1, 0));
    tbl[8]  = v(1, 0, 0, 0, o(3, 0, 1, 0, 1, 1, 0));
    tbl[9]  = v(1, 0, 0, 0, o(3, 0, 1, 0, 1, 1, 0));
    tbl[10] = v(0, 0, 1, 0, o(3, 1, 0, 1, 1, 1, 0));
    tbl[11] = v(1, 0, 1, 0, o(3, 1, 0, 1, 1, 1, 0));
    tbl[12] = v(0, 0, 1, 1, o(3, 0, 0, 0, 0, 1, 0));
    tbl[13] = v(0, 0, 1, 0, o(3, 0, 0, 0, 0, 1, 1));
    tbl[14] = v(0, 0, 1, 0, o(3, 0, 0, 0, 0, 1, 0));
    tbl[15] = v(0, 0, 1, 0, o(3, 0, 0, 0, 1, 1, 0));
    tbl[16] = v(0, 0, 1, 0, o(3, 0, 0, 0, 1, 0, 0));
    tbl[17] = v(0, 0, 1, 0, o(3, 0, 0, 0, 1, 0, 1));
    tbl[18] = v(0, 0, 1, 0, o(3, 0, 0, 0, 1, 0, 0));
    tbl[19] = v(0, 0, 1, 0, o(3, 0, 0, 0, 1, 1, 0));
    tbl[20] = v(0, 0, 1, 0, o(3, 0, 1, 0, 1, 1, 0));
    tbl[21] = v(0, 0, 0, 0, o(3, 0, 1, 0, 1, 1, 0));
    tbl[22] = v(0, 0, 1, 0, o(3, 1, 0, 1, 1, 1, 0));
    tbl[23] = v(0, 0, 0, 1, o(3, 0, 0, 0, 0, 1, 0));

    // Reset state
    model_reset();
    tick(); tick();
    check("reset_state", dut_out(), o(2, 0, 1, 0, 1, 1, 0));
    Reset = 0;
    tick();

    // Directed vector table
    for (int i = 0; i < 24; i++) begin
      Exp_increase = tbl[i].inc; Exp_decrease = tbl[i].dec;
      Init = tbl[i].init; Ovf5 = tbl[i].ovf;
      tick();
      check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
    end
    Exp_increase = 0; Exp_decrease = 0; Init = 0; Ovf5 = 0;
    repeat (8) tick();
    check("back_to_idle", dut_out(), o(3, 0, 1, 0, 1, 1, 0));

    // Saturation both ways
    repeat (30) press_inc();
    check1("sat_max", Exp_Time, 5'd30);
    repeat (30) press_dec();
    check1("sat_min", Exp_Time, 5'd2);

    // Held button counts once
    Exp_increase = 1; repeat (10) tick(); Exp_increase = 0; tick();
    check1("held_inc", Exp_Time, 5'd3);

    // Capture with Exp_Time = 8 and lockout
    repeat (5) press_inc();
    check1("exp_8", Exp_Time, 5'd8);
    Init = 1; tick(); Init = 0;
    check1("start_expose", {3'b0, Start, Expose}, 5'b00011);
    press_inc();
    Init = 1; tick(); Init = 0; tick();
    repeat (3) tick();
    Ovf5 = 1; tick(); Ovf5 = 0;
    check1("ovf_start_fall", {2'b0, Start, Expose, NRE_1}, 5'b00000);
    press_inc();
    Init = 1; tick(); Init = 0; tick();
    repeat (3) tick();
    check1("readout_end", {3'b0, Erase, ADC}, 5'b00000);
    tick();
    check("erase_after_readout", dut_out(), o(8, 0, 1, 0, 1, 1, 0));
    tick();
    check1("no_retrigger", {4'b0, Start}, 5'b00000);

    // Spurious Ovf5 in IDLE
    Ovf5 = 1; tick(); tick(); Ovf5 = 0;
    check("ovf_idle", dut_out(), o(8, 0, 1, 0, 1, 1, 0));

    // Async reset mid-readout
    Init = 1; tick(); Init = 0;
    Ovf5 = 1; tick(); Ovf5 = 0;
    tick(); tick();
    Reset = 1; #1;
    model_reset();
    check("reset_mid_readout", dut_out(), o(2, 0, 1, 0, 1, 1, 0));
    #1 Reset = 0;
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      Exp_increase = ($urandom_range(0, 2) == 0);
      Exp_decrease = ($urandom_range(0, 2) == 0);
      Init         = ($urandom_range(0, 3) == 0);
      Ovf5         = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/camera_ctrl.md
# camera_ctrl

Top-level control FSM of the digital camera. It sits directly upstream of the exposure timer: it drives the timer's `Start` and `Exp_Time` inputs and consumes its `Ovf5` end-of-exposure flag. It also holds the user-adjustable exposure time and sequences the pixel-array control lines (`Erase`, `Expose`, `NRE_1`, `NRE_2`, `ADC`) through the idle, exposure and readout phases.

## Interface
- `EXP_MIN`, default 2: minimum exposure time in ms, and the reset value of `Exp_Time`.
- `EXP_MAX`, default 30: maximum exposure time in ms.
- `RD_LEN`, default 8: number of readout cycles.

- `Clk`  in  1  system clock, 1 kHz (1 ms period).
- `Reset`  in  1  asynchronous, active-high reset. One clock; all state clears immediately on assertion.
- `Init`  in  1  take-picture request; acts on its rising edge.
- `Exp_increase`  in  1  button; each rising edge adds 1 ms to the exposure time.
- `Exp_decrease`  in  1  button; each rising edge subtracts 1 ms from the exposure time.
- `Ovf5`  in  1  timer flag: exposure time has elapsed.
- `Start`  out  1  enables the timer; held high for the whole exposure.
- `Exp_Time`  out  5  current exposure time in ms, from `EXP_MIN` to `EXP_MAX`.
- `Erase`  out  1  clears the pixel array; high in IDLE.
- `Expose`  out  1  opens the pixel array; high in EXPOSE.
- `NRE_1`  out  1  row-1 read enable, active low.
- `NRE_2`  out  1  row-2 read enable, active low.
- `ADC`  out  1  ADC sample strobe, active high.

## Operation
- Edge detection:
  - `Init`, `Exp_increase` and `Exp_decrease` each have a delayed copy, reset to 0.
  - Edge = input high AND delayed copy low.
  - Holding an input high produces exactly one edge.
- States (in the shared package): IDLE, EXPOSE, READOUT.
- IDLE:
  - `Erase`=1, `Expose`=0, `NRE_1`=`NRE_2`=1, `ADC`=0, `Start`=0.
  - An increase edge increments `Exp_Time`, saturating at `EXP_MAX`.
  - A decrease edge decrements `Exp_Time`, saturating at `EXP_MIN`.
  - Increase and decrease edges in the same cycle: no change.
  - An `Init` edge moves to EXPOSE. A button edge in that same cycle still applies.
- EXPOSE:
  - `Erase`=0, `Expose`=1, `Start`=1.
  - Button and `Init` edges are ignored; `Exp_Time` is frozen.
  - `Ovf5`=1 moves to READOUT and clears the readout counter.
- READOUT:
  - `Expose`=0, `Start`=0, `Erase`=0. A 3-bit counter `rd_cnt` runs 0 to `RD_LEN`-1.
  - Counts 0–2: `NRE_1`=0, with `ADC`=1 at count 1.
  - Count 3: all enables high (gap).
  - Counts 4–6: `NRE_2`=0, with `ADC`=1 at count 5.
  - Count 7: gap, then return to IDLE.
  - Button and `Init` edges are ignored.
- Reset mid-operation: return to IDLE immediately. `Exp_Time` = `EXP_MIN`, `Start`=0, `Erase`=1, `Expose`=0, `NRE_1`=`NRE_2`=1, `ADC`=0.
- `Ovf5` is ignored outside EXPOSE.

## Timing
- All outputs are registered and decoded from the next state and next counter value. They change on the same edge as the state.
- Reset values: state IDLE, `Exp_Time`=2, `Start`=0, `Erase`=1, `Expose`=0, `NRE_1`=1, `NRE_2`=1, `ADC`=0, `rd_cnt`=0, edge registers 0.
- `Init` rises before edge k: after edge k, `Start`=1, `Expose`=1, `Erase`=0.
- `Ovf5` is sampled high at edge m: after edge m, `Start`=0, `Expose`=0, `NRE_1`=0, `rd_cnt`=0.
- `ADC` pulses follow edges m+1 and m+5, one cycle each. `Erase` returns to 1 after edge m+8.
- A button edge updates `Exp_Time` one cycle after the input rises.
- A new `Init` edge is accepted from the first IDLE cycle after readout. `Init` must have been low at least one cycle before that.

## Structure
- Shared package `camera_pkg`: state enum (IDLE, EXPOSE, READOUT), `EXP_MIN`, `EXP_MAX`, `RD_LEN`, and the readout step constants (ADC1=1, GAP1=3, ADC2=5).
- Sub-module `edge_detect` (Clk, Reset, d, rise), instantiated three times.
- The FSM, exposure register and readout counter live in `camera_ctrl`.

## Test plan
- Reset: assert `Reset` mid-READOUT -> all outputs return to reset values immediately, and `Exp_Time`=2.
- Exposure adjust:
  - From 2, apply 30 increase pulses -> `Exp_Time`=30 (saturates).
  - Then apply 30 decrease pulses -> `Exp_Time`=2.
  - Increase and decrease together -> no change.
  - Holding `Exp_increase` high for 10 cycles -> +1 only.
- Capture with `Exp_Time`=8:
  - `Init` edge -> `Start`/`Expose` high.
  - Drive `Ovf5` 8 cycles later -> `Start` falls the next edge.
  - `NRE_1` is low for 3 cycles with `ADC` in the middle, then a 1-cycle gap, then the same pattern on `NRE_2`.
  - `Erase`=1 after 8 readout cycles.
- Lockout: increase pulses and `Init` during EXPOSE and READOUT -> `Exp_Time` unchanged and no re-trigger.
- `Init` held high through a full capture -> exactly one capture, and IDLE persists until `Init` toggles.
- Spurious `Ovf5` in IDLE -> no state change.
